// File: rtl/memory_read_unit.sv
// Load datapath: forms a read address, waits READ_LATENCY memory cycles, and
// writes the returned word back to exactly one register destination.
module memory_read_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  RdAddrSel,
  input  logic [1:0]  RdDst,
  input  logic [15:0] pc,
  input  logic [15:0] sp_in,
  input  logic [7:0]  imm_in,
  input  logic [15:0] MaryData,
  input  logic [15:0] ShelleyData,
  input  logic [15:0] mem_data,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic [15:0] wb_data,
  output logic        MaryWrite,
  output logic        ShelleyWrite,
  output logic        RAWrite,
  output logic        CompWrite,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state  | meaning
  // IDLE   | waiting for start
  // READ   | mem_read asserted, counting memory latency
  // WB     | one-cycle write-back pulse to the latched destination
  // ERR    | one-cycle rejection (misaligned address or illegal source)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [15:0] r_addr;
  logic [15:0] w_addr_nxt;
  logic [1:0]  r_dst;
  logic [1:0]  w_dst_nxt;
  logic [15:0] w_imm_sext;
  logic [15:0] w_addr_calc;
  logic        w_sel_illegal;
  logic        w_read_last;
  logic        r_mem_read;
  logic [15:0] r_wb_data;
  logic [3:0]  r_we;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  assign w_imm_sext    = {{8{imm_in[7]}}, imm_in};
  assign w_sel_illegal = RdAddrSel[2] & RdAddrSel[1];
  assign w_read_last   = (r_cnt == LAT_LAST);

  always_comb begin
    w_addr_calc = 16'h0000;
    case (RdAddrSel)
      3'b000:  w_addr_calc = pc;
      3'b001:  w_addr_calc = w_imm_sext;
      3'b010:  w_addr_calc = MaryData;
      3'b011:  w_addr_calc = ShelleyData;
      3'b100:  w_addr_calc = sp_in + 16'd2;
      3'b101:  w_addr_calc = sp_in + (w_imm_sext << 2);
      default: w_addr_calc = 16'h0000;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_dst_nxt   = r_dst;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_nxt  = w_addr_calc;
          w_dst_nxt   = RdDst;
          w_cnt_nxt   = 2'd0;
          w_state_nxt = (w_sel_illegal || w_addr_calc[0]) ? S_ERR : S_READ;
        end
      end
      S_READ: begin
        w_cnt_nxt = r_cnt + 2'd1;
        if (w_read_last) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_addr  <= 16'h0000;
      r_dst   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_dst   <= w_dst_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_read <= 1'b0;
      r_wb_data  <= 16'h0000;
      r_we       <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_read <= (w_state_nxt == S_READ);
      r_we       <= (w_state_nxt == S_WB) ? (4'b0001 << w_dst_nxt) : 4'b0000;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_WB) || (w_state_nxt == S_ERR);
      r_err      <= (w_state_nxt == S_ERR);
      if ((r_state == S_READ) && w_read_last) begin
        r_wb_data <= mem_data;
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_read     = r_mem_read;
  assign wb_data      = r_wb_data;
  assign MaryWrite    = r_we[0];
  assign ShelleyWrite = r_we[1];
  assign RAWrite      = r_we[2];
  assign CompWrite    = r_we[3];
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_memory_read_unit.sv
// Scoreboard bench: three instances (READ_LATENCY 1..3) share one stimulus stream;
// expected reads and completions are queued per instance and popped by a monitor.
module tb_memory_read_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  RdAddrSel;
  logic [1:0]  RdDst;
  logic [15:0] pc;
  logic [15:0] sp_in;
  logic [7:0]  imm_in;
  logic [15:0] MaryData;
  logic [15:0] ShelleyData;

  logic [15:0] mem_data_v [3];
  logic [15:0] mem_addr_v [3];
  logic        mem_read_v [3];
  logic [15:0] wb_data_v  [3];
  logic        mw_v [3];
  logic        sw_v [3];
  logic        rw_v [3];
  logic        cw_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        err_v  [3];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rd_run [3] = '{0, 0, 0};

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [3:0]  we;
    logic        err;
  } dn_exp_t;

  rd_exp_t rd_q [3][$];
  dn_exp_t dn_q [3][$];

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  memory_read_unit #(.READ_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .RdAddrSel(RdAddrSel), .RdDst(RdDst),
    .pc(pc), .sp_in(sp_in), .imm_in(imm_in), .MaryData(MaryData), .ShelleyData(ShelleyData),
    .mem_data(mem_data_v[0]), .mem_addr(mem_addr_v[0]), .mem_read(mem_read_v[0]),
    .wb_data(wb_data_v[0]), .MaryWrite(mw_v[0]), .ShelleyWrite(sw_v[0]), .RAWrite(rw_v[0]),
    .CompWrite(cw_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]));

  memory_read_unit #(.READ_LATENCY(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start), .RdAddrSel(RdAddrSel), .RdDst(RdDst),
    .pc(pc), .sp_in(sp_in), .imm_in(imm_in), .MaryData(MaryData), .ShelleyData(ShelleyData),
    .mem_data(mem_data_v[1]), .mem_addr(mem_addr_v[1]), .mem_read(mem_read_v[1]),
    .wb_data(wb_data_v[1]), .MaryWrite(mw_v[1]), .ShelleyWrite(sw_v[1]), .RAWrite(rw_v[1]),
    .CompWrite(cw_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]));

  memory_read_unit #(.READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .start(start), .RdAddrSel(RdAddrSel), .RdDst(RdDst),
    .pc(pc), .sp_in(sp_in), .imm_in(imm_in), .MaryData(MaryData), .ShelleyData(ShelleyData),
    .mem_data(mem_data_v[2]), .mem_addr(mem_addr_v[2]), .mem_read(mem_read_v[2]),
    .wb_data(wb_data_v[2]), .MaryWrite(mw_v[2]), .ShelleyWrite(sw_v[2]), .RAWrite(rw_v[2]),
    .CompWrite(cw_v[2]), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]));

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5C3);
  endfunction

  // Memory data is only valid from the L-th consecutive mem_read cycle onwards.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) rd_run[i] <= mem_read_v[i] ? rd_run[i] + 1 : 0;
  end

  assign mem_data_v[0] = mem_read_v[0] ? mem_word(mem_addr_v[0]) : 16'hDEAD;
  assign mem_data_v[1] = (mem_read_v[1] && rd_run[1] >= 1) ? mem_word(mem_addr_v[1]) : 16'hDEAD;
  assign mem_data_v[2] = (mem_read_v[2] && rd_run[2] >= 2) ? mem_word(mem_addr_v[2]) : 16'hDEAD;

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [L=%0d] cycle %0d: got %0h, expected %0h", name, inst + 1, cyc, act, exp);
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      logic [3:0] we;
      rd_exp_t    re;
      dn_exp_t    de;
      we = {cw_v[i], rw_v[i], sw_v[i], mw_v[i]};
      if (mem_read_v[i]) begin
        if (rd_q[i].size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_read [L=%0d] cycle %0d: mem_read=1 addr=%0h, expected mem_read=0",
                   i + 1, cyc, mem_addr_v[i]);
        end else begin
          re = rd_q[i].pop_front();
          check("read_cycle", i, 64'(cyc), 64'(re.cyc));
          check("read_addr", i, 64'(mem_addr_v[i]), 64'(re.addr));
        end
      end
      if (done_v[i]) begin
        if (dn_q[i].size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done [L=%0d] cycle %0d: done=1 err=%0b we=%0h, expected done=0",
                   i + 1, cyc, err_v[i], we);
        end else begin
          de = dn_q[i].pop_front();
          check("done_cycle", i, 64'(cyc), 64'(de.cyc));
          check("done_err", i, 64'(err_v[i]), 64'(de.err));
          check("done_we", i, 64'(we), 64'(de.we));
          check("done_busy", i, 64'(busy_v[i]), 64'd1);
          if (!de.err) check("wb_data", i, 64'(wb_data_v[i]), 64'(de.data));
        end
      end else begin
        check("we_outside_wb", i, 64'(we), 64'd0);
        check("err_without_done", i, 64'(err_v[i]), 64'd0);
      end
    end
  end

  task automatic chk_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      check(name, i, 64'({mem_addr_v[i], mem_read_v[i], wb_data_v[i], cw_v[i], rw_v[i], sw_v[i],
                          mw_v[i], busy_v[i], done_v[i], err_v[i]}), 64'd0);
    end
  endtask

  // Issue one start pulse at the current negedge and queue the hand-derived response.
  task automatic do_load(input logic [2:0] sel, input logic [1:0] dst, input logic [15:0] addr,
                         input logic [15:0] data, input logic ok);
    int t0;
    int end_c [3];
    RdAddrSel = sel;
    RdDst     = dst;
    start     = 1'b1;
    t0        = cyc;
    for (int i = 0; i < 3; i++) begin
      if (ok) begin
        for (int k = 1; k <= i + 1; k++) rd_q[i].push_back('{t0 + k, addr});
        dn_q[i].push_back('{t0 + i + 2, data, 4'b0001 << dst, 1'b0});
        end_c[i] = t0 + i + 2;
      end else begin
        dn_q[i].push_back('{t0 + 1, 16'h0000, 4'b0000, 1'b1});
        end_c[i] = t0 + 1;
      end
    end
    @(negedge clock);
    start       = 1'b0;
    pc          = 16'($urandom);
    sp_in       = 16'($urandom);
    imm_in      = 8'($urandom);
    MaryData    = 16'($urandom);
    ShelleyData = 16'($urandom);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 3; i++) check("busy", i, 64'(busy_v[i]), 64'(cyc <= end_c[i]));
      @(negedge clock);
    end
  endtask

  initial begin
    int t0;
    int t1;
    reset = 1'b1; start = 1'b0; RdAddrSel = 3'b000; RdDst = 2'b00;
    pc = 16'h0; sp_in = 16'h0; imm_in = 8'h0; MaryData = 16'h0; ShelleyData = 16'h0;
    repeat (3) @(negedge clock);
    chk_zero("reset_state");
    reset = 1'b0;
    @(negedge clock);
    chk_zero("idle_after_reset");

    MaryData = 16'h0040;
    do_load(3'b010, 2'b00, 16'h0040, 16'hBEEF, 1'b1);
    sp_in = 16'hFFFE;
    do_load(3'b100, 2'b10, 16'h0000, 16'hA5C3, 1'b1);
    sp_in = 16'h0100; imm_in = 8'hFE;
    do_load(3'b101, 2'b01, 16'h00F8, 16'hA53B, 1'b1);
    pc = 16'h1234;
    do_load(3'b000, 2'b11, 16'h1234, 16'hB7F7, 1'b1);
    imm_in = 8'h80;
    do_load(3'b001, 2'b01, 16'hFF80, 16'h5A43, 1'b1);
    ShelleyData = 16'h0013;
    do_load(3'b011, 2'b00, 16'h0000, 16'h0000, 1'b0);
    ShelleyData = 16'h0020;
    do_load(3'b111, 2'b10, 16'h0000, 16'h0000, 1'b0);
    ShelleyData = 16'h0020;
    do_load(3'b110, 2'b11, 16'h0000, 16'h0000, 1'b0);
    ShelleyData = 16'h2000;
    do_load(3'b011, 2'b00, 16'h2000, 16'h85C3, 1'b1);

    // start held for six cycles: second acceptance lands at cycle L+2 with the new MaryData
    MaryData = 16'h0040; RdAddrSel = 3'b010; RdDst = 2'b00; start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= i + 1; k++) rd_q[i].push_back('{t0 + k, 16'h0040});
      dn_q[i].push_back('{t0 + i + 2, 16'hBEEF, 4'b0001, 1'b0});
      t1 = t0 + i + 3;
      for (int k = 1; k <= i + 1; k++) rd_q[i].push_back('{t1 + k, 16'h0122});
      dn_q[i].push_back('{t1 + i + 2, 16'hA4E1, 4'b0001, 1'b0});
    end
    @(negedge clock);
    MaryData = 16'h0122;
    repeat (5) @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);

    // reset and start together: nothing is accepted
    reset = 1'b1; start = 1'b1; RdAddrSel = 3'b010; MaryData = 16'h0040;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk_zero("reset_beats_start");
    @(negedge clock);
    chk_zero("reset_beats_start_idle");

    // reset asserted during cycle 2: aborts L=2/3 mid-read, L=1 already finished its WB
    pc = 16'h1234; RdAddrSel = 3'b000; RdDst = 2'b11; start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= ((i + 1 < 2) ? i + 1 : 2); k++) rd_q[i].push_back('{t0 + k, 16'h1234});
      if (i == 0) dn_q[i].push_back('{t0 + 2, 16'hB7F7, 4'b1000, 1'b0});
    end
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_zero("after_mid_reset");
    sp_in = 16'hFFFE;
    do_load(3'b100, 2'b10, 16'h0000, 16'hA5C3, 1'b1);

    repeat (4) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("reads_outstanding", i, 64'(rd_q[i].size()), 64'd0);
      check("done_outstanding", i, 64'(dn_q[i].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
